sobel_frame_ctrl: RTL and testbench
===================================

Name: sobel_frame_ctrl

Overview:
- Frame sequencer between rgb2gray and the conv2d_box/conv2d chain.
- Passes grayscale pixels through with zero latency and tracks column, row and frame position.
- At end of frame, or when the input stalls past a timeout, it blocks input and injects flush pixels so the line-buffer stages drain the last rows.
- Reports frame completion and status to the top level.

Parameters:
- WIDTH_P, 8, pixel width in bits.
- LINE_W_P, 640, pixels per line.
- FRAME_H_P, 480, lines per frame.
- FLUSH_PIX_P, 4*LINE_W_P+4, number of flush pixels injected per frame; must be at least 1.
- FLUSH_VAL_P, 0, data value of each flush pixel (WIDTH_P bits).
- TIMEOUT_P, 0, idle cycles in PASS before a forced flush; 0 disables the timeout.

Ports:
- clk_i  in  1  core clock; the only clock.
- rstn_i  in  1  asynchronous active-low reset.
- data_i  in  WIDTH_P  upstream pixel.
- valid_i  in  1  upstream valid.
- ready_o  out  1  ready to upstream.
- data_o  out  WIDTH_P  pixel to the conv chain.
- valid_o  out  1  valid to the conv chain.
- ready_i  in  1  ready from the conv chain.
- sof_o  out  1  qualifies the current output beat as the first pixel of a frame.
- eol_o  out  1  qualifies the current output beat as the last pixel of a line.
- col_o  out  $clog2(LINE_W_P)  column of the next input pixel.
- row_o  out  $clog2(FRAME_H_P)  row of the next input pixel.
- busy_o  out  1  high whenever state is not IDLE.
- timeout_o  out  1  one-cycle pulse when a timeout forces a flush.
- frame_done_o  out  1  one-cycle pulse in DONE.
- frame_cnt_o  out  16  completed-frame count; wraps at 2^16.

Behaviour:
- Reset: asynchronous on rstn_i low.
  - Clears state to IDLE and zeroes col, row, flush, idle and frame counters.
  - While rstn_i is low, ready_o, valid_o, sof_o, eol_o, timeout_o, frame_done_o and busy_o are all 0.
- Handshake: a beat transfers only when valid and ready are both high. No valid-to-ready combinational path is created beyond the passthrough described below.
- States: IDLE, PASS, FLUSH, DONE.
- IDLE:
  - Combinational passthrough: data_o=data_i, valid_o=valid_i, ready_o=ready_i.
  - sof_o=valid_i.
  - On an accepted beat: move to PASS and advance the counters.
- PASS:
  - Same passthrough as IDLE; sof_o=0.
  - Accepted beat: col increments. At col=LINE_W_P-1, eol_o is high on that beat, col wraps to 0 and row increments.
  - Accepted beat at col=LINE_W_P-1 and row=FRAME_H_P-1: go to FLUSH; col and row go to 0.
  - Idle counter: resets on each accepted beat, otherwise increments.
  - If TIMEOUT_P>0 and the idle counter reaches TIMEOUT_P-1 with no accept in that cycle: pulse timeout_o, go to FLUSH, and clear col and row.
  - An accept in the same cycle as the timeout wins over the timeout.
- FLUSH:
  - ready_o=0; valid_o=1; data_o=FLUSH_VAL_P; eol_o and sof_o are 0.
  - The flush counter counts accepted beats, and valid_o stays high under backpressure.
  - After the FLUSH_PIX_P-th accepted beat, go to DONE.
- DONE:
  - Lasts exactly one cycle.
  - ready_o=0, valid_o=0, frame_done_o=1.
  - frame_cnt_o increments at the end of the cycle.
  - Flush and idle counters clear; next state is IDLE.
- Input held during FLUSH or DONE stays pending upstream and becomes the sof beat of the next frame.
- Counters are sized with $clog2. Flush counter width is $clog2(FLUSH_PIX_P+1); idle counter width is $clog2(TIMEOUT_P+1), minimum 1.
- Latency: 0 cycles in data passthrough. State change takes effect the cycle after the triggering event.

Test Plan (LINE_W_P=4, FRAME_H_P=3, FLUSH_PIX_P=5, TIMEOUT_P=8):
- Full frame: 12 pixels 1..12 with ready_i=1 -> 12 identical output beats; sof_o on beat 1; eol_o on beats 4, 8, 12; then 5 beats of data 0 with ready_o=0; frame_done_o for 1 cycle; frame_cnt_o=1; busy_o back to 0.
- Flush backpressure: ready_i alternating 1/0 during FLUSH -> valid_o held at 1 throughout; exactly 5 accepted zero beats before DONE.
- Timeout: 6 pixels sent, then valid_i=0 -> timeout_o pulse 8 cycles after the last accept; 5 flush beats; frame_done_o pulse; col_o=0, row_o=0.
- Timeout race: a pixel accepted in the cycle the idle counter hits 7 -> no timeout_o; remain in PASS; col_o advances.
- Pending input: valid_i=1 held through FLUSH and DONE with data 0xAA -> not accepted until IDLE; then accepted with sof_o=1 and data_o=0xAA.
- Reset mid-FLUSH after 2 flush beats -> outputs immediately 0; after release the state is IDLE, frame_cnt_o=0, and the next frame runs normally.

Source files
------------

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer between rgb2gray and the conv chain: zero-latency pixel passthrough
// with position tracking, plus end-of-frame / timeout flush injection to drain line buffers.
//
// Handshake: a beat transfers on a cycle where valid and ready are both high. In IDLE/PASS
// valid_o, ready_o and data_o are direct passthroughs; in FLUSH ready_o=0 and valid_o=1 is
// held until ready_i accepts; in DONE both valid_o and ready_o are 0.
module sobel_frame_ctrl #(
  parameter int WIDTH_P = 8,
  parameter int LINE_W_P = 640,
  parameter int FRAME_H_P = 480,
  parameter int FLUSH_PIX_P = 4 * LINE_W_P + 4,
  parameter logic [WIDTH_P-1:0] FLUSH_VAL_P = '0,
  parameter int TIMEOUT_P = 0,
  localparam int COL_W = (LINE_W_P > 1) ? $clog2(LINE_W_P) : 1,
  localparam int ROW_W = (FRAME_H_P > 1) ? $clog2(FRAME_H_P) : 1,
  localparam int FLUSH_W = (FLUSH_PIX_P > 1) ? $clog2(FLUSH_PIX_P + 1) : 1,
  localparam int IDLE_W = (TIMEOUT_P > 0) ? $clog2(TIMEOUT_P + 1) : 1
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [WIDTH_P-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [WIDTH_P-1:0] data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               sof_o,
  output logic               eol_o,
  output logic [COL_W-1:0]   col_o,
  output logic [ROW_W-1:0]   row_o,
  output logic               busy_o,
  output logic               timeout_o,
  output logic               frame_done_o,
  output logic [15:0]        frame_cnt_o,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(LINE_W_P - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(FRAME_H_P - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_PIX_P - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'((TIMEOUT_P > 0) ? TIMEOUT_P - 1 : 0);

  state_t             state;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [FLUSH_W-1:0] flush_cnt;
  logic [IDLE_W-1:0]  idle_cnt;
  logic [15:0]        frame_cnt;

  logic pass_mode;
  logic in_accept;
  logic flush_accept;
  logic line_end;
  logic frame_end;
  logic timeout_hit;

  assign pass_mode    = (state == S_IDLE) || (state == S_PASS);
  assign in_accept    = pass_mode && valid_i && ready_i;
  assign flush_accept = (state == S_FLUSH) && ready_i;
  assign line_end     = (col == COL_LAST);
  assign frame_end    = line_end && (row == ROW_LAST);
  // An accepted beat in the timeout cycle keeps the frame alive.
  assign timeout_hit  = (TIMEOUT_P > 0) && (state == S_PASS) &&
                        (idle_cnt == IDLE_LAST) && !in_accept;

  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    sof_o   = 1'b0;
    eol_o   = 1'b0;
    data_o  = data_i;
    if (rstn_i) begin
      case (state)
        S_IDLE, S_PASS: begin
          valid_o = valid_i;
          ready_o = ready_i;
          sof_o   = (state == S_IDLE) && valid_i;
          eol_o   = valid_i && line_end;
        end
        S_FLUSH: begin
          valid_o = 1'b1;
          data_o  = FLUSH_VAL_P;
        end
        default: begin
          valid_o = 1'b0;
          ready_o = 1'b0;
        end
      endcase
    end
  end

  assign col_o        = col;
  assign row_o        = row;
  assign busy_o       = (state != S_IDLE);
  assign timeout_o    = timeout_hit;
  assign frame_done_o = (state == S_DONE);
  assign frame_cnt_o  = frame_cnt;
  assign state_o      = state;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= S_IDLE;
      col       <= '0;
      row       <= '0;
      flush_cnt <= '0;
      idle_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        S_IDLE, S_PASS: begin
          if (in_accept) begin
            idle_cnt <= '0;
            if (frame_end) begin
              col   <= '0;
              row   <= '0;
              state <= S_FLUSH;
            end else if (line_end) begin
              col   <= '0;
              row   <= row + ROW_W'(1);
              state <= S_PASS;
            end else begin
              col   <= col + COL_W'(1);
              state <= S_PASS;
            end
          end else if (timeout_hit) begin
            col      <= '0;
            row      <= '0;
            idle_cnt <= '0;
            state    <= S_FLUSH;
          end else if ((state == S_PASS) && (TIMEOUT_P > 0)) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end
        S_FLUSH: begin
          if (flush_accept) begin
            flush_cnt <= flush_cnt + FLUSH_W'(1);
            if (flush_cnt == FLUSH_LAST) state <= S_DONE;
          end
        end
        default: begin
          frame_cnt <= frame_cnt + 16'd1;
          flush_cnt <= '0;
          idle_cnt  <= '0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl with a 4x3 frame, 5 flush pixels and an 8-cycle timeout.
module tb_sobel_frame_ctrl;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       sof_o;
  logic       eol_o;
  logic [1:0] col_o;
  logic [1:0] row_o;
  logic       busy_o;
  logic       timeout_o;
  logic       frame_done_o;
  logic [15:0] frame_cnt_o;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  sobel_frame_ctrl #(
    .WIDTH_P(8), .LINE_W_P(4), .FRAME_H_P(3), .FLUSH_PIX_P(5),
    .FLUSH_VAL_P(8'h00), .TIMEOUT_P(8)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .sof_o(sof_o), .eol_o(eol_o), .col_o(col_o), .row_o(row_o), .busy_o(busy_o),
    .timeout_o(timeout_o), .frame_done_o(frame_done_o), .frame_cnt_o(frame_cnt_o),
    .state_o(state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       vi, ri;
    logic [7:0] di;
    logic       ev, er, es, ee, eb, ef, et;
    logic [7:0] ed;
  } vec_t;

  function automatic vec_t mk(input logic vi, ri, input logic [7:0] di,
                              input logic ev, er, es, ee, eb, ef, et,
                              input logic [7:0] ed);
    vec_t v;
    v.vi = vi; v.ri = ri; v.di = di;
    v.ev = ev; v.er = er; v.es = es; v.ee = ee; v.eb = eb; v.ef = ef; v.et = et;
    v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: apply inputs at negedge, settle, then score any accepted output beat
  task automatic drive(input logic v, input logic r, input logic [7:0] d);
    @(negedge clk_i);
    valid_i = v;
    ready_i = r;
    data_i  = d;
    #1;
    if (valid_o && ready_i) begin
      if (exp_q.size() == 0) chk("sb_unexpected_beat", 32'(data_o), 32'hFFFF_FFFF);
      else chk("sb_data", 32'(data_o), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic send_px(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(8'(base + i));
      drive(1'b1, 1'b1, 8'(base + i));
    end
  endtask

  task automatic flush_done(input logic [15:0] exp_cnt);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h00);
      drive(1'b0, 1'b1, 8'h00);
    end
    drive(1'b0, 1'b1, 8'h00);
    chk("done_pulse", 32'(frame_done_o), 32'd1);
    drive(1'b0, 1'b1, 8'h00);
    chk("frame_cnt", 32'(frame_cnt_o), 32'(exp_cnt));
    chk("busy_idle", 32'(busy_o), 32'd0);
  endtask

  vec_t vecs[19];

  initial begin
    // full-frame table: 12 pixels, 5 flush beats, DONE, IDLE
    vecs[0] = mk(1, 1, 8'd1, 1, 1, 1, 0, 0, 0, 0, 8'd1);
    for (int k = 2; k <= 12; k++)
      vecs[k-1] = mk(1, 1, 8'(k), 1, 1, 0, (k % 4 == 0), 1, 0, 0, 8'(k));
    for (int k = 13; k <= 17; k++)
      vecs[k-1] = mk(0, 1, 8'd0, 1, 0, 0, 0, 1, 0, 0, 8'd0);
    vecs[17] = mk(0, 1, 8'd0, 0, 0, 0, 0, 1, 1, 0, 8'd0);
    vecs[18] = mk(0, 1, 8'd0, 0, 1, 0, 0, 0, 0, 0, 8'd0);

    rstn_i = 1'b0; valid_i = 1'b1; ready_i = 1'b1; data_i = 8'h55;
    #12;
    chk("reset_outs", 32'({valid_o, ready_o, sof_o, eol_o, busy_o, timeout_o, frame_done_o}), 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1; valid_i = 1'b0;
    #1;
    chk("reset_cnt", 32'({frame_cnt_o, col_o, row_o, state_o}), 32'd0);

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].ev && vecs[i].ri) exp_q.push_back(vecs[i].ed);
      drive(vecs[i].vi, vecs[i].ri, vecs[i].di);
      chk($sformatf("vec%0d", i),
          {17'd0, valid_o, ready_o, sof_o, eol_o, busy_o, frame_done_o, timeout_o,
           (vecs[i].ev ? data_o : 8'h00)},
          {17'd0, vecs[i].ev, vecs[i].er, vecs[i].es, vecs[i].ee, vecs[i].eb, vecs[i].ef,
           vecs[i].et, vecs[i].ed});
    end
    chk("frame1_cnt", 32'(frame_cnt_o), 32'd1);

    // flush under alternating backpressure: 9 cycles, 5 accepts
    send_px(12, 8'h20);
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0) exp_q.push_back(8'h00);
      drive(1'b0, (i % 2 == 0), 8'h00);
      chk("bp_valid_held", 32'({valid_o, ready_o, frame_done_o}), 32'b100);
    end
    drive(1'b0, 1'b1, 8'h00);
    chk("bp_done", 32'(frame_done_o), 32'd1);
    drive(1'b0, 1'b1, 8'h00);
    chk("bp_cnt", 32'(frame_cnt_o), 32'd2);

    // timeout after 6 pixels
    send_px(6, 8'h40);
    drive(1'b0, 1'b1, 8'h00);
    chk("to_pos", 32'({col_o, row_o}), 32'b1001);
    for (int t = 2; t <= 8; t++) begin
      drive(1'b0, 1'b1, 8'h00);
      chk($sformatf("to_pulse_t%0d", t), 32'(timeout_o), 32'(t == 8));
    end
    flush_done(16'd3);
    chk("to_pos_clr", 32'({col_o, row_o}), 32'd0);

    // timeout race: accept in the cycle idle hits 7
    send_px(1, 8'h60);
    for (int t = 1; t <= 7; t++) drive(1'b0, 1'b1, 8'h00);
    exp_q.push_back(8'h61);
    drive(1'b1, 1'b1, 8'h61);
    chk("race_no_to", 32'(timeout_o), 32'd0);
    drive(1'b0, 1'b1, 8'h00);
    chk("race_pass", 32'({busy_o, state_o, col_o, timeout_o}), 32'b1_01_10_0);
    send_px(10, 8'h62);
    flush_done(16'd4);

    // pending input held through FLUSH and DONE
    send_px(12, 8'h80);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h00);
      drive(1'b1, 1'b1, 8'hAA);
      chk("pend_flush", 32'({ready_o, valid_o, data_o}), 32'({1'b0, 1'b1, 8'h00}));
    end
    drive(1'b1, 1'b1, 8'hAA);
    chk("pend_done", 32'({ready_o, valid_o, frame_done_o}), 32'b001);
    exp_q.push_back(8'hAA);
    drive(1'b1, 1'b1, 8'hAA);
    chk("pend_sof", 32'({sof_o, ready_o, valid_o, data_o}), 32'({3'b111, 8'hAA}));
    chk("pend_cnt", 32'(frame_cnt_o), 32'd5);

    // reset in the middle of FLUSH after 2 flush beats
    send_px(11, 8'hB0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(8'h00);
      drive(1'b0, 1'b1, 8'h00);
    end
    @(negedge clk_i);
    rstn_i = 1'b0; valid_i = 1'b1; ready_i = 1'b1;
    #1;
    chk("rst_flush_outs", 32'({valid_o, ready_o, sof_o, eol_o, busy_o, timeout_o, frame_done_o}), 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1; valid_i = 1'b0;
    #1;
    chk("rst_flush_state", 32'({frame_cnt_o, state_o, col_o, row_o}), 32'd0);
    send_px(12, 8'hC0);
    flush_done(16'd1);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
